// File: rtl/sm_clk_gen_pkg.sv
// sm_clk_gen_pkg: mode and FSM state encodings shared by the clock generator files.
package sm_clk_gen_pkg;
  typedef enum logic [1:0] {
    MODE_HALT = 2'b00,
    MODE_RUN  = 2'b01,
    MODE_STEP = 2'b10,
    MODE_RUN2 = 2'b11
  } mode_e;
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_HIGH = 2'b01;
  localparam logic [1:0] S_LOW  = 2'b10;
  function automatic logic is_run(input logic [1:0] m);
    return m == MODE_RUN || m == MODE_RUN2;
  endfunction
  function automatic logic is_step(input logic [1:0] m);
    return m == MODE_STEP;
  endfunction
endpackage

// File: rtl/sm_clk_gen_if.sv
// sm_clk_gen_if: per-channel divide/mode/step controls and generated clock outputs.
interface sm_clk_gen_if #(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 24
);
  logic [CHANNELS*CNT_W-1:0] divide;
  logic [2*CHANNELS-1:0]     mode;
  logic [CHANNELS-1:0]       step;
  logic [CHANNELS-1:0]       clkOut;
  logic [CHANNELS-1:0]       tick;
  logic [CHANNELS-1:0]       busy;
  modport master (output divide, mode, step, input clkOut, tick, busy);
  modport slave (input divide, mode, step, output clkOut, tick, busy);
endinterface

// File: rtl/sm_clk_gen_channel.sv
// sm_clk_gen_channel: one glitch-free 50% divide-by-2(D+1) clock with run/halt/step modes;
// SM_CLK_GEN_SYNC_EN adds 2-flop synchronisers on mode and step.
module sm_clk_gen_channel
  import sm_clk_gen_pkg::*;
#(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] divide,
  input  logic [1:0]       mode,
  input  logic             step,
  output logic             slow_clk,
  output logic             tick,
  output logic             busy
);
  logic [1:0]       mode_s, state, nxt;
  logic             step_s, step_q, cnt_done, start, enter_high;
  logic [CNT_W-1:0] cnt, dsh;
`ifdef SM_CLK_GEN_SYNC_EN
  logic [1:0] mode_m;
  logic       step_m;
  always_ff @(posedge clk)
    if (rst) {mode_m, mode_s, step_m, step_s} <= '0;
    else {mode_m, mode_s, step_m, step_s} <= {mode, mode_m, step, step_m};
`else
  assign mode_s = mode;
  assign step_s = step;
`endif
  // mode only matters in IDLE and at the end of LOW, so periods are never cut short
  always_comb begin
    cnt_done   = cnt == dsh;
    start      = is_run(mode_s) || (is_step(mode_s) && step_s && !step_q);
    nxt        = state == S_IDLE ? (start ? S_HIGH : S_IDLE)
               : state == S_HIGH ? (cnt_done ? S_LOW : S_HIGH)
               : cnt_done ? (is_run(mode_s) ? S_HIGH : S_IDLE) : S_LOW;
    enter_high = nxt == S_HIGH && state != S_HIGH;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      dsh      <= '0;
      step_q   <= 1'b0;
      slow_clk <= 1'b0;
      tick     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= nxt;
      step_q   <= step_s;
      cnt      <= (nxt != state || nxt == S_IDLE) ? '0 : cnt + 1'b1;
      dsh      <= enter_high ? divide : dsh;
      slow_clk <= nxt == S_HIGH;
      tick     <= enter_high;
      busy     <= nxt != S_IDLE;
    end
endmodule

// File: rtl/sm_clk_gen.sv
// sm_clk_gen: CHANNELS independent stepped clock generators sliced from one bus;
// define SM_CLK_GEN_SYNC_EN to synchronise mode/step inside each channel.
module sm_clk_gen
  import sm_clk_gen_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 24
) (
  input logic         clkIn,
  input logic         rst,
  sm_clk_gen_if.slave bus
);
  logic [CHANNELS-1:0] slow, tick, busy;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    sm_clk_gen_channel #(.CNT_W(CNT_W)) u_ch (
      .clk     (clkIn),
      .rst     (rst),
      .divide  (bus.divide[i*CNT_W +: CNT_W]),
      .mode    (bus.mode[2*i +: 2]),
      .step    (bus.step[i]),
      .slow_clk(slow[i]),
      .tick    (tick[i]),
      .busy    (busy[i])
    );
  end
  assign bus.clkOut = slow;
  assign bus.tick   = tick;
  assign bus.busy   = busy;
endmodule

// File: tb/tb_sm_clk_gen.sv
// tb_sm_clk_gen: scoreboard bench; expected {clkOut,tick,busy} per cycle queued per channel.
module tb_sm_clk_gen;
  import sm_clk_gen_pkg::*;
`ifdef SM_CLK_GEN_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  sm_clk_gen_if #(.CHANNELS(2), .CNT_W(24)) bus ();
  sm_clk_gen #(.CHANNELS(2), .CNT_W(24)) dut (.clkIn(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  logic [2:0] q0[$];
  logic [2:0] q1[$];
  logic [2:0] e, o;
  function automatic logic [2:0] obs(input int ch);
    return {bus.clkOut[ch], bus.tick[ch], bus.busy[ch]};
  endfunction
  task automatic push(input int ch, input logic [2:0] v);
    if (ch == 0) q0.push_back(v);
    else q1.push_back(v);
  endtask
  task automatic push_idle(input int ch, input int n);
    repeat (n) push(ch, 3'b000);
  endtask
  task automatic push_period(input int ch, input int d);
    for (int i = 0; i <= d; i++) push(ch, i == 0 ? 3'b111 : 3'b101);
    repeat (d + 1) push(ch, 3'b001);
  endtask
  task automatic set_ch(input int ch, input int d, input logic [1:0] m);
    bus.divide[ch*24 +: 24] = 24'(d);
    bus.mode[ch*2 +: 2] = m;
  endtask
  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    bus.mode = '0;
    bus.step = '0;
    bus.divide = '0;
    repeat (2) @(negedge clk);
    q0.delete();
    q1.delete();
  endtask
  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({bus.clkOut, bus.tick, bus.busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_state got %b exp 000000", {bus.clkOut, bus.tick, bus.busy});
    end
    set_ch(0, 3, MODE_RUN);
    set_ch(1, 3, MODE_RUN);
    rst = 1'b0;
    push_idle(0, LAT - 1); push_period(0, 3);
    push_idle(1, LAT - 1); push_period(1, 3);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (q0.size() > 0) begin e = q0.pop_front(); o = obs(0); checks++; if (o !== e) begin errors++; $display("FAIL reset_pre_ch0 c=%0d got %b exp %b", c, o, e); end end
      if (q1.size() > 0) begin e = q1.pop_front(); o = obs(1); checks++; if (o !== e) begin errors++; $display("FAIL reset_pre_ch1 c=%0d got %b exp %b", c, o, e); end end
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.clkOut, bus.tick, bus.busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_mid got %b exp 000000", {bus.clkOut, bus.tick, bus.busy});
    end
    rst = 1'b0;
    q0.delete(); q1.delete();
    push_idle(0, LAT - 1); push_period(0, 3);
    push_idle(1, LAT - 1); push_period(1, 3);
    for (int c = 0; c < LAT + 7; c++) begin
      @(negedge clk);
      if (q0.size() > 0) begin e = q0.pop_front(); o = obs(0); checks++; if (o !== e) begin errors++; $display("FAIL reset_post_ch0 c=%0d got %b exp %b", c, o, e); end end
      if (q1.size() > 0) begin e = q1.pop_front(); o = obs(1); checks++; if (o !== e) begin errors++; $display("FAIL reset_post_ch1 c=%0d got %b exp %b", c, o, e); end end
    end
  endtask
  task automatic test_run_period;
    int n;
    do_reset;
    set_ch(0, 3, MODE_RUN);
    rst = 1'b0;
    push_idle(0, LAT - 1);
    repeat (3) push_period(0, 3);
    push_idle(1, LAT - 1 + 24);
    n = 0;
    for (int c = 0; c < LAT - 1 + 24; c++) begin
      @(negedge clk);
      if (bus.tick[0]) n++;
      if (q0.size() > 0) begin e = q0.pop_front(); o = obs(0); checks++; if (o !== e) begin errors++; $display("FAIL run_d3_ch0 c=%0d got %b exp %b", c, o, e); end end
      if (q1.size() > 0) begin e = q1.pop_front(); o = obs(1); checks++; if (o !== e) begin errors++; $display("FAIL run_d3_ch1 c=%0d got %b exp %b", c, o, e); end end
    end
    checks++;
    if (n != 3) begin errors++; $display("FAIL run_ticks got %0d exp 3", n); end
    do_reset;
    set_ch(0, 0, MODE_RUN);
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.clkOut[0] && n < 10);
    checks++;
    if (n != LAT) begin errors++; $display("FAIL run_latency got %0d exp %0d", n, LAT); end
    do_reset;
    set_ch(0, 0, MODE_RUN);
    rst = 1'b0;
    push_idle(0, LAT - 1);
    repeat (4) push_period(0, 0);
    for (int c = 0; c < LAT - 1 + 8; c++) begin
      @(negedge clk);
      if (q0.size() > 0) begin e = q0.pop_front(); o = obs(0); checks++; if (o !== e) begin errors++; $display("FAIL run_d0 c=%0d got %b exp %b", c, o, e); end end
    end
  endtask
  task automatic test_divide_change;
    do_reset;
    set_ch(0, 4, MODE_RUN);
    rst = 1'b0;
    push_idle(0, LAT - 1);
    push_period(0, 4);
    repeat (2) push_period(0, 1);
    for (int c = 0; c < LAT - 1 + 18; c++) begin
      @(negedge clk);
      if (q0.size() > 0) begin e = q0.pop_front(); o = obs(0); checks++; if (o !== e) begin errors++; $display("FAIL div_change c=%0d got %b exp %b", c, o, e); end end
      if (c == LAT) set_ch(0, 1, MODE_RUN);
    end
  endtask
  task automatic test_halt;
    do_reset;
    set_ch(0, 2, MODE_RUN);
    rst = 1'b0;
    push_idle(0, LAT - 1);
    push_period(0, 2);
    push_idle(0, 8);
    for (int c = 0; c < LAT - 1 + 14; c++) begin
      @(negedge clk);
      if (q0.size() > 0) begin e = q0.pop_front(); o = obs(0); checks++; if (o !== e) begin errors++; $display("FAIL halt c=%0d got %b exp %b", c, o, e); end end
      if (c == LAT - 1) set_ch(0, 2, MODE_HALT);
    end
  endtask
  task automatic test_single_step;
    int nt, nb;
    do_reset;
    set_ch(0, 2, MODE_STEP);
    rst = 1'b0;
    bus.step[0] = 1'b1;
    push_idle(0, LAT - 1);
    push_period(0, 2);
    push_idle(0, 20 - (LAT - 1) - 6);
    nt = 0;
    nb = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.tick[0]) nt++;
      if (bus.busy[0]) nb++;
      if (q0.size() > 0) begin e = q0.pop_front(); o = obs(0); checks++; if (o !== e) begin errors++; $display("FAIL step_hold c=%0d got %b exp %b", c, o, e); end end
    end
    checks++;
    if (nt != 1) begin errors++; $display("FAIL step_ticks got %0d exp 1", nt); end
    checks++;
    if (nb != 6) begin errors++; $display("FAIL step_busy_len got %0d exp 6", nb); end
    bus.step[0] = 1'b0;
    push_idle(0, 2 + LAT - 1);
    push_period(0, 2);
    push_idle(0, 6);
    for (int c = 0; c < LAT + 13; c++) begin
      @(negedge clk);
      if (q0.size() > 0) begin e = q0.pop_front(); o = obs(0); checks++; if (o !== e) begin errors++; $display("FAIL step_busy_edge c=%0d got %b exp %b", c, o, e); end end
      if (c == 1 || c == LAT + 2) bus.step[0] = 1'b1;
      if (c == LAT + 1) bus.step[0] = 1'b0;
    end
    bus.step[0] = 1'b0;
    push_idle(0, 2 + LAT - 1);
    push_period(0, 2);
    push_idle(0, 6);
    for (int c = 0; c < LAT + 13; c++) begin
      @(negedge clk);
      if (q0.size() > 0) begin e = q0.pop_front(); o = obs(0); checks++; if (o !== e) begin errors++; $display("FAIL step_end_edge c=%0d got %b exp %b", c, o, e); end end
      if (c == 1 || c == 7) bus.step[0] = 1'b1;
      if (c == LAT + 1) bus.step[0] = 1'b0;
    end
    bus.step[0] = 1'b0;
    push_idle(0, 2 + LAT - 1);
    push_period(0, 2);
    push_idle(0, 2);
    for (int c = 0; c < LAT + 9; c++) begin
      @(negedge clk);
      if (q0.size() > 0) begin e = q0.pop_front(); o = obs(0); checks++; if (o !== e) begin errors++; $display("FAIL step_again c=%0d got %b exp %b", c, o, e); end end
      if (c == 1) bus.step[0] = 1'b1;
    end
  endtask
  task automatic test_independence;
    do_reset;
    set_ch(0, 1, MODE_RUN);
    set_ch(1, 5, MODE_STEP);
    rst = 1'b0;
    bus.step[1] = 1'b1;
    push_idle(0, LAT - 1);
    repeat (6) push_period(0, 1);
    push_idle(1, LAT - 1);
    push_period(1, 5);
    push_idle(1, 12);
    for (int c = 0; c < LAT - 1 + 24; c++) begin
      @(negedge clk);
      if (q0.size() > 0) begin e = q0.pop_front(); o = obs(0); checks++; if (o !== e) begin errors++; $display("FAIL indep_ch0 c=%0d got %b exp %b", c, o, e); end end
      if (q1.size() > 0) begin e = q1.pop_front(); o = obs(1); checks++; if (o !== e) begin errors++; $display("FAIL indep_ch1 c=%0d got %b exp %b", c, o, e); end end
    end
  endtask
  initial begin
    bus.divide = '0;
    bus.mode = '0;
    bus.step = '0;
    test_reset;
    test_run_period;
    test_divide_change;
    test_halt;
    test_single_step;
    test_independence;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
